// File: rtl/count_seq_if.sv
// Host-side control bundle for the event-counter sequencer.
// The host (master) drives commands and parameters; the sequencer (slave)
// returns counter controls, the shadow count and the status pulses.
interface count_seq_if #(
  parameter int WIDTH    = 3,
  parameter int ROUNDS_W = 4
) ();

  logic                start;
  logic                stop;
  logic                abort;
  logic [WIDTH-1:0]    mod_val;
  logic [ROUNDS_W-1:0] rounds;

  logic                cnt_en;
  logic                cnt_clr;
  logic [WIDTH-1:0]    count;
  logic                tc;
  logic                done;
  logic                busy;
  logic                err;

  modport master (
    output start, stop, abort, mod_val, rounds,
    input  cnt_en, cnt_clr, count, tc, done, busy, err
  );

  modport slave (
    input  start, stop, abort, mod_val, rounds,
    output cnt_en, cnt_clr, count, tc, done, busy, err
  );

endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencer for the 3-bit event-counter datapath.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a start with non-zero terminal value and rounds
//   RUN   | counting; cnt_en high, shadow count advances every edge
//   PAUSE | stopped by host; count and round counter hold
//   DONE  | last wrap taken; one-cycle done pulse, then back to IDLE
//
// Per-edge priority is abort > stop > start > count. All outputs are
// registered: the combinational block computes the next value of every
// output and the register block loads them together.
module count_seq_ctrl #(
  parameter int WIDTH    = 3,
  parameter int ROUNDS_W = 4
) (
  input  logic        clk,
  input  logic        res,
  count_seq_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state,      state_n;
  logic [WIDTH-1:0]    count_q,    count_n;
  logic [ROUNDS_W-1:0] round_cnt,  round_n;
  logic [WIDTH-1:0]    mod_lat,    mod_n;
  logic [ROUNDS_W-1:0] rounds_lat, rounds_n;
  logic                tc_q,       tc_n;
  logic                clr_q,      clr_n;
  logic                err_q,      err_n;
  logic                en_q,       en_n;
  logic                busy_q,     busy_n;
  logic                done_q,     done_n;

  logic [ROUNDS_W-1:0] round_inc;
  logic                param_ok;
  logic                at_wrap;

  assign round_inc = round_cnt + 1'b1;
  assign param_ok  = (bus.mod_val != '0) && (bus.rounds != '0);
  // The count never exceeds the latched terminal value, so equality is the wrap test.
  assign at_wrap   = (count_q == mod_lat);

  // Next-state and next-output computation for one clock edge.
  always_comb begin
    state_n  = state;
    count_n  = count_q;
    round_n  = round_cnt;
    mod_n    = mod_lat;
    rounds_n = rounds_lat;
    tc_n     = 1'b0;
    clr_n    = 1'b0;
    err_n    = 1'b0;

    if (bus.abort) begin
      state_n = IDLE;
      count_n = '0;
      round_n = '0;
      clr_n   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (param_ok) begin
              state_n  = RUN;
              mod_n    = bus.mod_val;
              rounds_n = bus.rounds;
              count_n  = '0;
              round_n  = '0;
              clr_n    = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        RUN: begin
          // A stop on the wrap edge wins; the wrap is taken after resume.
          if (bus.stop) begin
            state_n = PAUSE;
          end else if (at_wrap) begin
            count_n = '0;
            tc_n    = 1'b1;
            round_n = round_inc;
            if (round_inc == rounds_lat) begin
              state_n = DONE;
            end
          end else begin
            count_n = count_q + 1'b1;
          end
        end
        PAUSE: begin
          if (bus.start) begin
            state_n = RUN;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    en_n   = (state_n == RUN);
    busy_n = (state_n == RUN) || (state_n == PAUSE);
    done_n = (state_n == DONE);
  end

  // State, datapath shadow and registered outputs.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= IDLE;
      count_q    <= '0;
      round_cnt  <= '0;
      mod_lat    <= '0;
      rounds_lat <= '0;
      tc_q       <= 1'b0;
      clr_q      <= 1'b0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      count_q    <= count_n;
      round_cnt  <= round_n;
      mod_lat    <= mod_n;
      rounds_lat <= rounds_n;
      tc_q       <= tc_n;
      clr_q      <= clr_n;
      err_q      <= err_n;
      en_q       <= en_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
    end
  end

  assign bus.cnt_en  = en_q;
  assign bus.cnt_clr = clr_q;
  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: reset, basic run, pause/resume,
// illegal start, abort priority, stop on wrap edge and async reset mid-run.
module tb_count_seq_ctrl;

  logic clk;
  logic res;
  int   checks;
  int   errors;

  count_seq_if #(.WIDTH(3), .ROUNDS_W(4)) bus ();

  count_seq_ctrl #(.WIDTH(3), .ROUNDS_W(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic ab,
                       input logic [2:0] mv, input logic [3:0] rn);
    bus.start   = st;
    bus.stop    = sp;
    bus.abort   = ab;
    bus.mod_val = mv;
    bus.rounds  = rn;
  endtask

  // Compares {cnt_en, cnt_clr, count, tc, done, busy, err} in one go.
  task automatic chk(input string tag, input logic en, input logic clr,
                     input logic [2:0] cnt, input logic tc, input logic dn,
                     input logic bsy, input logic er);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {bus.cnt_en, bus.cnt_clr, bus.count, bus.tc, bus.done, bus.busy, bus.err};
    exp = {en, clr, cnt, tc, dn, bsy, er};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed en/clr/cnt/tc/done/busy/err=%b required %b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    res = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);

    // 1: reset held with toggling inputs, then release
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i[0], ~i[0], 3'd3, 4'd2);
      tick();
      chk($sformatf("reset_hold_%0d", i), 0, 0, 3'd0, 0, 0, 0, 0);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    #2 res = 1'b1;
    tick();
    chk("reset_release", 0, 0, 3'd0, 0, 0, 0, 0);

    // 2: mod=3 rounds=2, done 8 edges after RUN entry
    drive(1'b1, 1'b0, 1'b0, 3'd3, 4'd2);
    tick();
    chk("basic_entry", 1, 1, 3'd0, 0, 0, 1, 0);
    drive(1'b0, 1'b0, 1'b0, 3'd5, 4'd9);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("basic_e%0d", i), (i != 8), 0, 3'(i % 4), (i % 4 == 0),
          (i == 8), (i != 8), 0);
    end
    tick();
    chk("basic_idle", 0, 0, 3'd0, 0, 0, 0, 0);

    // 3: mod=7 rounds=1, pause at count 4 for 5 cycles, resume
    drive(1'b1, 1'b0, 1'b0, 3'd7, 4'd1);
    tick();
    chk("pause_entry", 1, 1, 3'd0, 0, 0, 1, 0);
    drive(1'b0, 1'b0, 1'b0, 3'd7, 4'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("pause_run_%0d", i), 1, 0, 3'(i), 0, 0, 1, 0);
    end
    bus.stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("pause_hold_%0d", i), 0, 0, 3'd4, 0, 0, 1, 0);
    end
    bus.stop  = 1'b0;
    bus.start = 1'b1;
    tick();
    chk("pause_resume", 1, 0, 3'd4, 0, 0, 1, 0);
    bus.start = 1'b0;
    tick(); chk("pause_c5", 1, 0, 3'd5, 0, 0, 1, 0);
    tick(); chk("pause_c6", 1, 0, 3'd6, 0, 0, 1, 0);
    tick(); chk("pause_c7", 1, 0, 3'd7, 0, 0, 1, 0);
    tick(); chk("pause_done", 0, 0, 3'd0, 1, 1, 0, 0);
    tick(); chk("pause_idle", 0, 0, 3'd0, 0, 0, 0, 0);

    // 4: illegal start with zero mod_val, then zero rounds
    drive(1'b1, 1'b0, 1'b0, 3'd0, 4'd3);
    tick();
    chk("illegal_mod0", 0, 0, 3'd0, 0, 0, 0, 1);
    drive(1'b1, 1'b0, 1'b0, 3'd5, 4'd0);
    tick();
    chk("illegal_rounds0", 0, 0, 3'd0, 0, 0, 0, 1);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    tick();
    chk("illegal_idle", 0, 0, 3'd0, 0, 0, 0, 0);

    // 5a: abort beats stop and start at count 2
    drive(1'b1, 1'b0, 1'b0, 3'd3, 4'd2);
    tick();
    chk("abort_entry", 1, 1, 3'd0, 0, 0, 1, 0);
    bus.start = 1'b0;
    tick(); chk("abort_c1", 1, 0, 3'd1, 0, 0, 1, 0);
    tick(); chk("abort_c2", 1, 0, 3'd2, 0, 0, 1, 0);
    drive(1'b1, 1'b1, 1'b1, 3'd3, 4'd2);
    tick();
    chk("abort_hit", 0, 1, 3'd0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 3'd3, 4'd2);
    tick();
    chk("abort_idle", 0, 0, 3'd0, 0, 0, 0, 0);

    // 5b: stop on the wrap edge pauses without tc; wrap after resume
    bus.start = 1'b1;
    tick();
    chk("wrapstop_entry", 1, 1, 3'd0, 0, 0, 1, 0);
    bus.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("wrapstop_c%0d", i), 1, 0, 3'(i), 0, 0, 1, 0);
    end
    bus.stop = 1'b1;
    tick();
    chk("wrapstop_pause", 0, 0, 3'd3, 0, 0, 1, 0);
    bus.stop  = 1'b0;
    bus.start = 1'b1;
    tick();
    chk("wrapstop_resume", 1, 0, 3'd3, 0, 0, 1, 0);
    bus.start = 1'b0;
    tick();
    chk("wrapstop_wrap", 1, 0, 3'd0, 1, 0, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("wrapstop_r2_%0d", i), 1, 0, 3'(i), 0, 0, 1, 0);
    end
    tick();
    chk("wrapstop_done", 0, 0, 3'd0, 1, 1, 0, 0);
    tick();
    chk("wrapstop_idle", 0, 0, 3'd0, 0, 0, 0, 0);

    // 6: async reset at count 5 of round 1, then a fresh full sequence
    drive(1'b1, 1'b0, 1'b0, 3'd7, 4'd2);
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 13; i++) tick();
    chk("areset_pre", 1, 0, 3'd5, 0, 0, 1, 0);
    #2 res = 1'b0;
    #1;
    chk("areset_now", 0, 0, 3'd0, 0, 0, 0, 0);
    tick();
    chk("areset_held", 0, 0, 3'd0, 0, 0, 0, 0);
    #2 res = 1'b1;
    tick();
    chk("areset_idle", 0, 0, 3'd0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 3'd1, 4'd3);
    tick();
    chk("rerun_entry", 1, 1, 3'd0, 0, 0, 1, 0);
    bus.start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("rerun_e%0d", i), (i != 6), 0, 3'(i % 2), (i % 2 == 0),
          (i == 6), (i != 6), 0);
    end
    tick();
    chk("rerun_idle", 0, 0, 3'd0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
